adder_rr_sequencer: RTL and testbench
=====================================

// Module: adder_rr_sequencer
// PURPOSE
//  Shares one multi-cycle 64-bit adder datapath between NUM_REQ requesters in the FPGA fabric.
//  Round-robin arbitration grants one job at a time. The sum is computed SLICE_W bits per cycle
//  with a registered carry chain. Result, carry and requester id are returned on a valid/ready port.
//  Sits between the HPS-driven operand registers (or fabric masters) and the sum readback path.
// PARAMETERS
//  NUM_REQ  2   number of requesters, >=1
//  DATA_W   64  operand/sum width
//  SLICE_W  16  bits added per cycle; DATA_W % SLICE_W must be 0 (elaboration error otherwise)
// PORTS
//  clk_clk        in   1                 single clock, all logic rising-edge
//  reset_reset_n  in   1                 asynchronous active-low reset
//  req_valid      in   NUM_REQ           per-requester job valid
//  req_ready      out  NUM_REQ           per-requester accept, at most one bit set
//  req_a          in   NUM_REQ*DATA_W    operand A, requester i at [i*DATA_W +: DATA_W]
//  req_b          in   NUM_REQ*DATA_W    operand B, same packing
//  rsp_valid      out  1                 result valid
//  rsp_ready      in   1                 result consumed
//  rsp_sum        out  DATA_W            A+B (wrapped, or saturated; see CONFIGURATION)
//  rsp_carry      out  1                 unsigned carry out of the MSB
//  rsp_ovf        out  1                 signed overflow (carry into MSB xor carry out)
//  rsp_id         out  ID_W              index of the served requester; ID_W = max(1, clog2(NUM_REQ))
//  busy           out  1                 high whenever state != IDLE
// BEHAVIOUR
//  States: IDLE -> CALC -> RESP -> IDLE. NSLICE = DATA_W/SLICE_W.
//  Reset: state=IDLE, rr pointer=0, rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_ovf=0, rsp_id=0, busy=0, carry reg=0.
//  IDLE: req_ready[i] = grant[i]. grant is combinational round-robin over req_valid, searched from pointer upward with wrap.
//   Accept = req_valid[i] & req_ready[i]. On accept:
//   - latch A, B and id; clear carry and slice counter.
//   - pointer <= (winner+1) mod NUM_REQ; go to CALC.
//   No request pending: stay in IDLE and hold the pointer.
//  Requesters hold valid, a and b stable until ready. Dropping valid before ready is legal; no job is taken.
//  CALC: each cycle adds slice k, bits [k*SLICE_W +: SLICE_W], plus the carry register.
//   Store the slice sum and update the carry. k counts 0..NSLICE-1.
//   After the slice NSLICE-1 edge, go to RESP and set rsp_valid=1.
//  req_ready=0 in CALC and RESP.
//  Latency: rsp_valid rises NSLICE edges after the accepting edge (4 for the defaults).
//  RESP: rsp_* hold stable while rsp_valid=1 & rsp_ready=0.
//   On rsp_valid & rsp_ready, go to IDLE with rsp_valid=0.
//   No new job is accepted in that same cycle: one bubble, throughput 1 job per NSLICE+2 cycles.
//  rsp_sum and flags hold their last values while idle.
//  Simultaneous requests: the grant goes to the lowest index >= pointer, so a requester waits at most NUM_REQ-1 jobs.
//  Wrap-around: 0xFFFF_FFFF_FFFF_FFFF + 1 -> sum 0, carry=1, ovf=0.
//  Reset mid-operation: the in-flight job is discarded, no response is issued, all state returns to reset values.
// CONFIGURATION
//  Macro ADDER_SIGNED_SAT_EN. Defined: when rsp_ovf=1, rsp_sum is clamped in RESP.
//   Clamp value is 0x7FF..F if A's MSB=0, else 0x800..0. rsp_carry and rsp_ovf are unchanged. Latency is unchanged.
//  Not defined: rsp_sum is the modulo-2^DATA_W sum and no clamp logic is built.
// STRUCTURE
//  Package adder_rr_pkg:
//   - state enum {IDLE, CALC, RESP}
//   - clog2 helper function
//   - localparams NSLICE and ID_W, derived from the parameters
//  Sub-module adder_rr_arbiter (NUM_REQ): inputs req_valid, pointer; output one-hot grant and winner index. Purely combinational.
//  Top holds the FSM, operand/carry/slice registers and the response register.
// TESTING
//  1 Single job: req0 A=5, B=7 -> req_ready[0] for one cycle; rsp_valid 4 edges later; sum=12, carry=0, ovf=0, id=0.
//  2 Contention: req0 and req1 both valid from reset -> served order id 0, 1, 0, 1 (pointer rotation); each response carries its own operands.
//  3 Wrap: A=0xFFFF_FFFF_FFFF_FFFF, B=1 -> sum=0, carry=1, ovf=0.
//   Carry across a slice: A=0x0000_0000_0000_FFFF, B=1 -> sum=0x1_0000.
//  4 Backpressure: hold rsp_ready=0 for 10 cycles -> rsp_* stable and req_ready all 0.
//   Release -> one bubble cycle, then the next grant.
//  5 Overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> ovf=1.
//   Sum is 0x8000_0000_0000_0000 without the macro, 0x7FFF_FFFF_FFFF_FFFF with ADDER_SIGNED_SAT_EN.
//  6 Reset in CALC: assert reset_reset_n=0 after slice 1 -> no rsp_valid, busy=0, pointer=0; the next job completes normally.

Source files
------------

// File: rtl/adder_rr_pkg.sv
// adder_rr_pkg: shared state encoding, width helpers and default-derived constants for the adder sequencer
package adder_rr_pkg;

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    localparam int NUM_REQ_DEF = 2;
    localparam int DATA_W_DEF  = 64;
    localparam int SLICE_W_DEF = 16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int id_width(input int n);
        return (clog2(n) > 1) ? clog2(n) : 1;
    endfunction

    localparam int NSLICE = DATA_W_DEF / SLICE_W_DEF;
    localparam int ID_W   = id_width(NUM_REQ_DEF);

endpackage

// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter: combinational round-robin grant, searched upward from the pointer with wrap
module adder_rr_arbiter
    import adder_rr_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = id_width(NUM_REQ_DEF)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    pointer,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    winner
);

    // walk from the farthest offset down so the nearest valid requester at or above the pointer wins
    always_comb begin
        int idx;
        grant  = '0;
        winner = '0;
        idx    = 0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            idx = (int'(pointer) + j) % NUM_REQ;
            if (req_valid[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                winner     = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/adder_rr_sequencer.sv
// adder_rr_sequencer: round-robin shared multi-cycle sliced adder; macro ADDER_SIGNED_SAT_EN enables signed saturation
module adder_rr_sequencer
    import adder_rr_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SLICE_W = SLICE_W_DEF
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_W-1:0]           rsp_sum,
    output logic                        rsp_carry,
    output logic                        rsp_ovf,
    output logic [id_width(NUM_REQ)-1:0] rsp_id,
    output logic                        busy
);

    localparam int NSL = DATA_W / SLICE_W;
    localparam int IW  = id_width(NUM_REQ);
    localparam int KW  = id_width(NSL);

    generate
        if (DATA_W % SLICE_W != 0) begin : g_bad_slice
            $error("DATA_W must be a multiple of SLICE_W");
        end
    endgenerate

    state_t              state, state_nxt;
    logic [IW-1:0]       pointer, winner, id;
    logic [NUM_REQ-1:0]  grant;
    logic [DATA_W-1:0]   a_q, b_q, sum_q, sum_w, res_w;
    logic [SLICE_W-1:0]  slice_s;
    logic [KW-1:0]       k;
    logic                carry, c_out, last, ovf_w, accept;

    adder_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(IW)) u_arb (
        .req_valid (req_valid),
        .pointer   (pointer),
        .grant     (grant),
        .winner    (winner)
    );

    assign accept    = (state == IDLE) && |grant;
    assign req_ready = (state == IDLE) ? grant : '0;
    assign busy      = state != IDLE;
    assign rsp_valid = state == RESP;
    assign last      = int'(k) == NSL - 1;

    // one slice of the add per cycle; overflow is only meaningful on the top slice
    always_comb begin
        {c_out, slice_s} = {1'b0, a_q[int'(k)*SLICE_W +: SLICE_W]} + {1'b0, b_q[int'(k)*SLICE_W +: SLICE_W]}
                         + {{SLICE_W{1'b0}}, carry};
        sum_w = sum_q;
        sum_w[int'(k)*SLICE_W +: SLICE_W] = slice_s;
        ovf_w = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (slice_s[SLICE_W-1] != a_q[DATA_W-1]);
`ifdef ADDER_SIGNED_SAT_EN
        res_w = ovf_w ? {a_q[DATA_W-1], {(DATA_W-1){~a_q[DATA_W-1]}}} : sum_w;
`else
        res_w = sum_w;
`endif
    end

    // next state: accept a grant, finish after the top slice, release on the response handshake
    always_comb begin
        state_nxt = state;
        if (accept) state_nxt = CALC;
        else if (state == CALC && last) state_nxt = RESP;
        else if (state == RESP && rsp_ready) state_nxt = IDLE;
    end

    // state register, operand capture, slice accumulation and response register
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state     <= IDLE;
            pointer   <= '0;
            id        <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            carry     <= 1'b0;
            k         <= '0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            rsp_ovf   <= 1'b0;
            rsp_id    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_q     <= req_a[int'(winner)*DATA_W +: DATA_W];
                b_q     <= req_b[int'(winner)*DATA_W +: DATA_W];
                id      <= winner;
                carry   <= 1'b0;
                k       <= '0;
                pointer <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + IW'(1);
            end else if (state == CALC) begin
                sum_q <= sum_w;
                carry <= c_out;
                k     <= k + KW'(1);
                if (last) begin
                    rsp_sum   <= res_w;
                    rsp_carry <= c_out;
                    rsp_ovf   <= ovf_w;
                    rsp_id    <= id;
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_rr_sequencer.sv
// tb_adder_rr_sequencer: scoreboard bench with a cycle-level reference model for the round-robin adder
module tb_adder_rr_sequencer;
    import adder_rr_pkg::*;

    localparam int N  = NUM_REQ_DEF;
    localparam int W  = DATA_W_DEF;
    localparam int NS = NSLICE;
    localparam int IW = ID_W;

    typedef struct {
        logic [W-1:0] sum;
        logic         c;
        logic         o;
        int           id;
    } exp_t;

    logic           clk, rst_n;
    logic [N-1:0]   req_valid, req_ready;
    logic [N*W-1:0] req_a, req_b;
    logic           rsp_valid, rsp_ready, rsp_carry, rsp_ovf, busy;
    logic [W-1:0]   rsp_sum;
    logic [IW-1:0]  rsp_id;

    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    int   ord[$];
    logic [N-1:0] took;
    bit   m_idle = 1'b1;
    bit   m_rsp = 1'b0;
    int   m_calc = 0;
    int   m_ptr = 0;

    adder_rr_sequencer dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_sum       (rsp_sum),
        .rsp_carry     (rsp_carry),
        .rsp_ovf       (rsp_ovf),
        .rsp_id        (rsp_id),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [N-1:0] rr(input logic [N-1:0] v, input int p);
        for (int j = 0; j < N; j++)
            if (v[(p + j) % N]) return N'(1) << ((p + j) % N);
        return '0;
    endfunction

    function automatic exp_t model_add(input logic [W-1:0] a, input logic [W-1:0] b, input int id);
        exp_t e;
        logic [W:0] s;
        s    = {1'b0, a} + {1'b0, b};
        e.sum = s[W-1:0];
        e.c   = s[W];
        e.o   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        e.id  = id;
`ifdef ADDER_SIGNED_SAT_EN
        if (e.o) e.sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        return e;
    endfunction

    function automatic logic [W-1:0] rnd();
        case ($urandom % 6)
            0: return '1;
            1: return '0;
            2: return {1'b0, {(W-1){1'b1}}};
            3: return {1'b1, {(W-1){1'b0}}};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // reference model: grant, busy and response timing expected on each cycle
    always @(negedge clk) begin
        logic [N-1:0] g;
        if (!rst_n) begin
            chk("busy_in_reset", busy, 0);
            chk("rsp_valid_in_reset", rsp_valid, 0);
            m_idle = 1'b1;
            m_rsp  = 1'b0;
            m_calc = 0;
            m_ptr  = 0;
            exp_q.delete();
        end else begin
            g = m_idle ? rr(req_valid, m_ptr) : '0;
            chk("req_ready", req_ready, g);
            chk("busy", busy, !m_idle);
            chk("rsp_valid", rsp_valid, m_rsp);
            if (g != 0) begin
                for (int i = 0; i < N; i++)
                    if (g[i]) begin
                        exp_q.push_back(model_add(req_a[i*W +: W], req_b[i*W +: W], i));
                        m_ptr = (i + 1) % N;
                    end
                m_idle = 1'b0;
                m_calc = NS;
            end else if (m_calc > 0) begin
                m_calc--;
                if (m_calc == 0) m_rsp = 1'b1;
            end else if (m_rsp && rsp_ready) begin
                m_rsp  = 1'b0;
                m_idle = 1'b1;
            end
        end
    end

    // scoreboard monitor: every presented response must match the oldest expected one
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                chk("rsp_sum", rsp_sum, exp_q[0].sum);
                chk("rsp_carry", rsp_carry, exp_q[0].c);
                chk("rsp_ovf", rsp_ovf, exp_q[0].o);
                chk("rsp_id", rsp_id, exp_q[0].id);
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(negedge clk);
        took = req_valid & req_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid[i] = 1'b1;
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        for (int t = 0; t < 100; t++) begin
            step();
            if (took[i]) break;
        end
        chk("issue_accepted", took[i], 1);
        req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 200; t++) begin
            if (exp_q.size() == 0 && !busy) break;
            step();
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        took = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_sum", rsp_sum, 0);
        chk("reset_carry", rsp_carry, 0);
        chk("reset_ovf", rsp_ovf, 0);
        chk("reset_id", rsp_id, 0);
        chk("reset_ready", req_ready, 0);
        rst_n = 1'b1;

        issue(0, 64'd5, 64'd7);
        drain();
        issue(0, '1, 64'd1);
        issue(1, 64'h0000_0000_0000_FFFF, 64'd1);
        issue(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        issue(1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        drain();

        req_valid = '1;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = rnd();
            req_b[i*W +: W] = rnd();
        end
        ord.delete();
        for (int t = 0; t < 200 && ord.size() < 4; t++) begin
            step();
            for (int i = 0; i < N; i++)
                if (took[i]) begin
                    ord.push_back(i);
                    req_a[i*W +: W] = rnd();
                    req_b[i*W +: W] = rnd();
                end
        end
        req_valid = '0;
        chk("order_len", ord.size(), 4);
        for (int j = 0; j < 4; j++)
            chk($sformatf("order%0d", j), (ord.size() > j) ? ord[j] : 99, j % 2);
        drain();

        rsp_ready = 1'b0;
        issue(1, rnd(), rnd());
        req_valid[0] = 1'b1;
        req_a[0 +: W] = rnd();
        req_b[0 +: W] = rnd();
        repeat (NS + 10) step();
        rsp_ready = 1'b1;
        n = 0;
        for (int t = 0; t < 20; t++) begin
            step();
            n++;
            if (took[0]) break;
        end
        chk("bubble_gap", n, 2);
        req_valid = '0;
        drain();

        issue(0, rnd(), rnd());
        step();
        step();
        rst_n = 1'b0;
        step();
        step();
        chk("midrst_sum", rsp_sum, 0);
        chk("midrst_busy", busy, 0);
        rst_n = 1'b1;
        req_valid = '1;
        for (int t = 0; t < 20; t++) begin
            step();
            if (took != 0) break;
        end
        chk("ptr_after_reset", took, 1);
        req_valid = '0;
        drain();

        for (int c = 0; c < 400; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (took[i] || (req_valid[i] && $urandom % 8 == 0)) req_valid[i] = 1'b0;
                else if (!req_valid[i] && $urandom % 3 == 0) begin
                    req_valid[i] = 1'b1;
                    req_a[i*W +: W] = rnd();
                    req_b[i*W +: W] = rnd();
                end
            end
            rsp_ready = ($urandom % 4) != 0;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
        $finish;
    end

endmodule
